piso_serializer: RTL and testbench

- Parallel-in, serial-out shift register with a load handshake; the transmit-side counterpart to the team's SIPO deserializer.
- Accepts a WIDTH-bit word and emits it one bit per clock, with a valid strobe and a last-bit marker.
- Supports back-to-back words with no idle gap, so it can feed a SIPO directly to form a serial link.

---
 rtl/piso_serializer.sv | 102 ++++++++++
 tb/tb_piso_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift register with a load
// handshake. A WIDTH-bit word is emitted one bit per clock with a valid
// strobe and a last-bit marker; back-to-back words leave no idle gap.
// Optional even-parity trailer bit: define PISO_PARITY_EN.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] Data_in,
   output logic             Data_out,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CNT_W = (FL > 1) ? $clog2(FL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FL - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             accept;
`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
   logic             parity_bit;
`endif

   // Bit that leaves the word first, depending on shift direction.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Move the next bit into the head position.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   // Ready in IDLE or on the final bit of a frame, so a new word can
   // follow the current one with no gap.
   assign load_ready = (state == IDLE) || out_last;
   assign accept     = load_valid && load_ready;
   assign cnt_next   = cnt + 1'b1;

   // Frame sequencer: load, shift, and return to idle at end of frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         Data_out  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else if (accept) begin
         // Fresh word: first bit goes straight out, the rest waits in shreg.
         state     <= SHIFT;
         shreg     <= advance(Data_in);
         cnt       <= '0;
         Data_out  <= head_bit(Data_in);
         out_valid <= 1'b1;
         out_last  <= (LAST_IDX == '0);
         busy      <= 1'b1;
`ifdef PISO_PARITY_EN
         parity_bit <= ^Data_in;
`endif
      end else if (state == SHIFT && !out_last) begin
         shreg     <= advance(shreg);
         cnt       <= cnt_next;
`ifdef PISO_PARITY_EN
         Data_out  <= (cnt_next == PAR_IDX) ? parity_bit : head_bit(shreg);
`else
         Data_out  <= head_bit(shreg);
`endif
         out_valid <= 1'b1;
         out_last  <= (cnt_next == LAST_IDX);
      end else begin
         // Idle, or frame finished with nothing waiting to follow.
         state     <= IDLE;
         cnt       <= '0;
         Data_out  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives two serializers (MSB-first and LSB-first) with
// the same stimulus and compares them against a frame-level model that
// lists each frame's bits in transmit order.
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] Data_in;
   logic         rdy_m, dout_m, vld_m, last_m, busy_m;
   logic         rdy_l, dout_l, vld_l, last_l, busy_l;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m),
      .Data_in(Data_in), .Data_out(dout_m), .out_valid(vld_m),
      .out_last(last_m), .busy(busy_m));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l),
      .Data_in(Data_in), .Data_out(dout_l), .out_valid(vld_l),
      .out_last(last_l), .busy(busy_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: current frame bits in send order, and position (-1 = idle).
   bit   fm [FL];
   bit   fl [FL];
   int   pos = -1;
   bit   last_acc;
   logic [15:0] sm, sl;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_frame(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         fm[i] = d[W-1-i];
         fl[i] = d[i];
      end
`ifdef PISO_PARITY_EN
      fm[W] = ^d;
      fl[W] = ^d;
`endif
   endtask

   task automatic check_outputs();
      bit ev, em, el, last;
      ev = (pos >= 0);
      em = 1'b0;
      el = 1'b0;
      if (pos >= 0) begin
         em = fm[pos];
         el = fl[pos];
      end
      last = (pos == FL - 1);
      chk("valid_m", 16'(vld_m), 16'(ev));
      chk("valid_l", 16'(vld_l), 16'(ev));
      chk("dout_m",  16'(dout_m), 16'(em));
      chk("dout_l",  16'(dout_l), 16'(el));
      chk("last_m",  16'(last_m), 16'(last));
      chk("last_l",  16'(last_l), 16'(last));
      chk("busy_m",  16'(busy_m), 16'(ev));
      chk("busy_l",  16'(busy_l), 16'(ev));
   endtask

   // One clock: drive at negedge, check ready, advance model at posedge,
   // then check registered outputs just after the edge.
   task automatic step(input bit lv, input logic [W-1:0] d);
      bit exp_rdy;
      @(negedge clk);
      load_valid = lv;
      Data_in    = d;
      #1;
      exp_rdy = (pos < 0) || (pos == FL - 1);
      chk("ready_m", 16'(rdy_m), 16'(exp_rdy));
      chk("ready_l", 16'(rdy_l), 16'(exp_rdy));
      last_acc = lv && exp_rdy;
      @(posedge clk);
      if (last_acc) begin
         build_frame(d);
         pos = 0;
      end else if (pos >= 0 && pos < FL - 1) begin
         pos++;
      end else begin
         pos = -1;
      end
      #1;
      check_outputs();
      if (vld_m) sm = {sm[14:0], dout_m};
      if (vld_l) sl = {sl[14:0], dout_l};
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   initial begin
      bit          lv_r;
      logic [W-1:0] d_r;
      bit          pending;
      logic [15:0] exp_sm, exp_sl;

      rst = 1'b1;
      load_valid = 1'b0;
      Data_in = '0;
      sm = '0;
      sl = '0;
      repeat (3) @(negedge clk);
      #1;
      check_outputs();
      chk("rst_ready", 16'(rdy_m & rdy_l), 16'd1);
      rst = 1'b0;

      // Idle after reset release.
      idle_steps(10);

      // Single word 1011.
      sm = '0; sl = '0;
      step(1'b1, 4'b1011);
      idle_steps(FL + 1);
`ifdef PISO_PARITY_EN
      exp_sm = 16'b10111; exp_sl = 16'b11011;
`else
      exp_sm = 16'b1011;  exp_sl = 16'b1101;
`endif
      chk("stream_1011_m", sm, exp_sm);
      chk("stream_1011_l", sl, exp_sl);

      // Back-to-back A then 5, second word held until accepted.
      sm = '0; sl = '0;
      step(1'b1, 4'hA);
      for (int i = 0; i < FL; i++) step(1'b1, 4'h5);
      idle_steps(FL + 1);
`ifdef PISO_PARITY_EN
      exp_sm = 16'b1010001010; exp_sl = 16'b0101010100;
`else
      exp_sm = 16'hA5;         exp_sl = 16'h5A;
`endif
      chk("stream_b2b_m", sm, exp_sm);
      chk("stream_b2b_l", sl, exp_sl);

      // Load pulsed mid-frame is ignored.
      sm = 16'hFFFF; sl = 16'hFFFF;
      step(1'b1, 4'h0);
      step(1'b1, 4'hF);
      idle_steps(FL + 1);
      chk("stream_ign_m", 16'(sm[FL-1:0]), 16'd0);
      chk("stream_ign_l", 16'(sl[FL-1:0]), 16'd0);

      // Parity-relevant words (model covers both builds).
      sm = '0;
      step(1'b1, 4'b1101);
      idle_steps(FL + 1);
`ifdef PISO_PARITY_EN
      chk("stream_par1_m", sm, 16'b11011);
`else
      chk("stream_1101_m", sm, 16'b1101);
`endif
      sm = '0;
      step(1'b1, 4'b1001);
      idle_steps(FL + 1);
`ifdef PISO_PARITY_EN
      chk("stream_par0_m", sm, 16'b10010);
`else
      chk("stream_1001_m", sm, 16'b1001);
`endif

      // Asynchronous reset in the middle of a frame.
      step(1'b1, 4'hB);
      step(1'b0, '0);
      step(1'b0, '0);
      #2;
      rst = 1'b1;
      #1;
      pos = -1;
      check_outputs();
      chk("abort_ready", 16'(rdy_m & rdy_l), 16'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_steps(FL + 2);

      // Randomized traffic; an offered word is held until accepted.
      pending = 1'b0;
      lv_r = 1'b0;
      d_r = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pending) begin
            lv_r = ($urandom_range(0, 3) != 0);
            d_r  = W'($urandom);
         end
         step(lv_r, d_r);
         pending = lv_r && !last_acc;
      end
      idle_steps(FL + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
